// File: rtl/systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_ctrl
// Purpose  : Buffers A/B from a host load port, streams k-slices into an
//            N_SIZE x N_SIZE systolic array, captures C rows and returns them
//            over a valid/ready port. Define SYSTOLIC_CTRL_PERF_EN to add the
//            perf_cycles busy-cycle counter output.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_ctrl #(
    parameter int DATAWIDTH     = 16,
    parameter int N_SIZE        = 5,
    parameter int DRAIN_TIMEOUT = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
`ifdef SYSTOLIC_CTRL_PERF_EN
    output logic [31:0]                   perf_cycles,
`endif
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic                          ld_sel,
    input  logic [$clog2(N_SIZE)-1:0]     ld_row,
    input  logic [N_SIZE*DATAWIDTH-1:0]   ld_data,
    output logic                          sa_valid_in,
    output logic [N_SIZE*DATAWIDTH-1:0]   sa_a,
    output logic [N_SIZE*DATAWIDTH-1:0]   sa_b,
    input  logic                          sa_valid_out,
    input  logic [N_SIZE*2*DATAWIDTH-1:0] sa_c,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [$clog2(N_SIZE)-1:0]     res_row,
    output logic [N_SIZE*2*DATAWIDTH-1:0] res_data
);

    localparam int c_RW = $clog2(N_SIZE);
    localparam int c_CW = 2 * DATAWIDTH;
    localparam int c_TW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [c_RW-1:0] c_LAST = c_RW'(N_SIZE - 1);
    localparam logic [c_TW-1:0] c_TIMER_END = c_TW'(DRAIN_TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]           r_state;
    logic [c_RW-1:0]      r_k;
    logic [c_RW-1:0]      r_cap;
    logic [c_RW-1:0]      r_m;
    logic [c_TW-1:0]      r_timer;
    logic [DATAWIDTH-1:0] r_a [N_SIZE][N_SIZE];
    logic [DATAWIDTH-1:0] r_b [N_SIZE][N_SIZE];
    logic [c_CW-1:0]      r_c [N_SIZE][N_SIZE];

    logic [DATAWIDTH-1:0]          w_a_view [N_SIZE][N_SIZE];
    logic [DATAWIDTH-1:0]          w_b_view [N_SIZE][N_SIZE];
    logic [N_SIZE*DATAWIDTH-1:0]   w_slice_a;
    logic [N_SIZE*DATAWIDTH-1:0]   w_slice_b;
    logic [N_SIZE*c_CW-1:0]        w_res_next;
    logic [c_RW-1:0]               w_k_next;
    logic [c_RW-1:0]               w_res_idx;
    logic                          w_ld_we;
    logic                          w_cap;
    logic                          w_last_cap;
    logic                          w_timeout;

    assign ld_ready   = (r_state == S_IDLE);
    assign w_ld_we    = ld_valid && ld_ready && ({1'b0, ld_row} < (c_RW + 1)'(N_SIZE));
    assign w_cap      = sa_valid_out && (r_state == S_DRAIN);
    assign w_last_cap = w_cap && (r_cap == c_LAST);
    assign w_timeout  = (r_timer == c_TIMER_END);

    // Buffer views with the in-flight load forwarded, so a same-cycle write+start feeds new data
    for (genvar i = 0; i < N_SIZE; i++) begin : g_view_row
        for (genvar j = 0; j < N_SIZE; j++) begin : g_view_col
            assign w_a_view[i][j] = (w_ld_we && !ld_sel && (ld_row == c_RW'(i)))
                                    ? ld_data[j*DATAWIDTH +: DATAWIDTH] : r_a[i][j];
            assign w_b_view[i][j] = (w_ld_we && ld_sel && (ld_row == c_RW'(i)))
                                    ? ld_data[j*DATAWIDTH +: DATAWIDTH] : r_b[i][j];
        end
    end

    always_comb begin
        w_k_next = '0;
        if (r_state == S_FEED && r_k != c_LAST) begin
            w_k_next = r_k + 1'b1;
        end
    end

    always_comb begin
        w_res_idx = '0;
        if (r_state == S_DONE && r_m != c_LAST) begin
            w_res_idx = r_m + 1'b1;
        end
    end

    for (genvar i = 0; i < N_SIZE; i++) begin : g_lane
        assign w_slice_a[i*DATAWIDTH +: DATAWIDTH] = w_a_view[i][w_k_next];
        assign w_slice_b[i*DATAWIDTH +: DATAWIDTH] = w_b_view[w_k_next][i];
        // Row 0 may be captured on the very edge that enters DONE via timeout
        assign w_res_next[i*c_CW +: c_CW] = (w_cap && (r_cap == w_res_idx))
                                            ? sa_c[i*c_CW +: c_CW] : r_c[w_res_idx][i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_cap       <= '0;
            r_m         <= '0;
            r_timer     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            sa_valid_in <= 1'b0;
            sa_a        <= '0;
            sa_b        <= '0;
            res_valid   <= 1'b0;
            res_row     <= '0;
            res_data    <= '0;
            for (int i = 0; i < N_SIZE; i++) begin
                for (int j = 0; j < N_SIZE; j++) begin
                    r_a[i][j] <= '0;
                    r_b[i][j] <= '0;
                    r_c[i][j] <= '0;
                end
            end
`ifdef SYSTOLIC_CTRL_PERF_EN
            perf_cycles <= '0;
`endif
        end else begin
            done <= 1'b0;

            if (w_ld_we) begin
                for (int j = 0; j < N_SIZE; j++) begin
                    if (ld_sel) begin
                        r_b[ld_row][j] <= ld_data[j*DATAWIDTH +: DATAWIDTH];
                    end else begin
                        r_a[ld_row][j] <= ld_data[j*DATAWIDTH +: DATAWIDTH];
                    end
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_FEED;
                        busy        <= 1'b1;
                        err         <= 1'b0;
                        r_k         <= '0;
                        sa_valid_in <= 1'b1;
                        sa_a        <= w_slice_a;
                        sa_b        <= w_slice_b;
                    end
                end

                S_FEED: begin
                    if (r_k == c_LAST) begin
                        r_state     <= S_DRAIN;
                        sa_valid_in <= 1'b0;
                        sa_a        <= '0;
                        sa_b        <= '0;
                        r_cap       <= '0;
                        r_timer     <= '0;
                    end else begin
                        r_k  <= r_k + 1'b1;
                        sa_a <= w_slice_a;
                        sa_b <= w_slice_b;
                    end
                end

                S_DRAIN: begin
                    if (w_cap) begin
                        for (int j = 0; j < N_SIZE; j++) begin
                            r_c[r_cap][j] <= sa_c[j*c_CW +: c_CW];
                        end
                        r_cap <= r_cap + 1'b1;
                    end
                    if (w_last_cap || w_timeout) begin
                        r_state   <= S_DONE;
                        res_valid <= 1'b1;
                        res_row   <= '0;
                        res_data  <= w_res_next;
                        r_m       <= '0;
                        if (!w_last_cap) begin
                            err <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_DONE: begin
                    if (res_ready) begin
                        if (r_m == c_LAST) begin
                            r_state   <= S_IDLE;
                            busy      <= 1'b0;
                            res_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            r_m      <= w_res_idx;
                            res_row  <= w_res_idx;
                            res_data <= w_res_next;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase

`ifdef SYSTOLIC_CTRL_PERF_EN
            if (r_state == S_IDLE) begin
                if (start) begin
                    perf_cycles <= '0;
                end
            end else if (perf_cycles != 32'hFFFF_FFFF) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_ctrl
// Purpose  : Self-checking bench for systolic_ctrl with a behavioural array
//            model and a plain matrix-product reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_ctrl;

    localparam int N  = 5;
    localparam int DW = 16;
    localparam int CW = 32;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            busy, done, err;
    logic            ld_valid = 1'b0;
    logic            ld_ready;
    logic            ld_sel = 1'b0;
    logic [2:0]      ld_row = '0;
    logic [N*DW-1:0] ld_data = '0;
    logic            sa_valid_in;
    logic [N*DW-1:0] sa_a, sa_b;
    logic            sa_valid_out;
    logic [N*CW-1:0] sa_c;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [2:0]      res_row;
    logic [N*CW-1:0] res_data;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0]     perf_cycles;
`endif

    always #5 clk = ~clk;

    systolic_ctrl #(.DATAWIDTH(DW), .N_SIZE(N), .DRAIN_TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .err          (err),
`ifdef SYSTOLIC_CTRL_PERF_EN
        .perf_cycles  (perf_cycles),
`endif
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_sel       (ld_sel),
        .ld_row       (ld_row),
        .ld_data      (ld_data),
        .sa_valid_in  (sa_valid_in),
        .sa_a         (sa_a),
        .sa_b         (sa_b),
        .sa_valid_out (sa_valid_out),
        .sa_c         (sa_c),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_row      (res_row),
        .res_data     (res_data)
    );

    logic [DW-1:0] ma [N][N];
    logic [DW-1:0] mb [N][N];
    logic [CW-1:0] ec [N][N];
    int checks = 0;
    int failures = 0;
    bit model_en = 1'b1;
    int gap_pct = 0;
    int got_n, done_cnt, stall_bad;
    bit timed_out;
    int got_row [16];
    logic [N*CW-1:0] got_d [16];

    // Array model: accumulates outer products of the streamed slices, then emits rows with random gaps
    logic [CW-1:0] acc [N][N];
    int m_slices, m_rows_left, m_next_row;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_slices     <= 0;
            m_rows_left  <= 0;
            m_next_row   <= 0;
            sa_valid_out <= 1'b0;
            sa_c         <= '0;
        end else if (sa_valid_in) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    acc[i][j] <= ((m_slices == 0) ? 32'd0 : acc[i][j])
                                 + 32'(sa_a[i*DW +: DW]) * 32'(sa_b[j*DW +: DW]);
            sa_valid_out <= 1'b0;
            if (m_slices == N - 1) begin
                m_slices    <= 0;
                m_rows_left <= N;
                m_next_row  <= 0;
            end else begin
                m_slices    <= m_slices + 1;
                m_rows_left <= 0;
            end
        end else if (m_rows_left > 0 && model_en && ($urandom_range(0, 99) >= gap_pct)) begin
            sa_valid_out <= 1'b1;
            for (int j = 0; j < N; j++) sa_c[j*CW +: CW] <= acc[m_next_row][j];
            m_next_row  <= m_next_row + 1;
            m_rows_left <= m_rows_left - 1;
        end else begin
            sa_valid_out <= 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_row(input bit sel, input int row, input logic [N*DW-1:0] data);
        ld_valid = 1'b1; ld_sel = sel; ld_row = 3'(row); ld_data = data;
        tick;
        ld_valid = 1'b0;
        if (row < N)
            for (int j = 0; j < N; j++)
                if (sel) mb[row][j] = data[j*DW +: DW];
                else     ma[row][j] = data[j*DW +: DW];
    endtask

    task automatic compute_expected;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                logic [CW-1:0] s = '0;
                for (int k = 0; k < N; k++) s = s + 32'(ma[i][k]) * 32'(mb[k][j]);
                ec[i][j] = s;
            end
    endtask

    function automatic logic [N*CW-1:0] exp_row(input int r);
        logic [N*CW-1:0] v;
        for (int j = 0; j < N; j++) v[j*CW +: CW] = ec[r][j];
        return v;
    endfunction

    // kind 0: random (+ an out-of-range row that must be dropped), 1: identity/ramp, 2: all ones
    task automatic load_mats(input int kind);
        for (int s = 0; s < 2; s++)
            for (int r = 0; r < N; r++) begin
                logic [N*DW-1:0] d;
                for (int j = 0; j < N; j++)
                    case (kind)
                        0:       d[j*DW +: DW] = 16'($urandom);
                        1:       d[j*DW +: DW] = (s == 0) ? ((r == j) ? 16'd1 : 16'd0) : 16'(r*5 + j + 1);
                        default: d[j*DW +: DW] = 16'hFFFF;
                    endcase
                load_row(s[0], r, d);
            end
        if (kind == 0) load_row($urandom_range(0, 1) == 1, $urandom_range(N, 7), {N{16'($urandom)}});
        compute_expected;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready, 2: stall 10 valid cycles then toggle
    task automatic run_collect(input int mode);
        logic [2:0] prow;
        logic [N*CW-1:0] pdata;
        bit pstall = 1'b0;
        int vcyc = 0;
        got_n = 0; done_cnt = 0; stall_bad = 0; timed_out = 1'b1;
        prow = '0; pdata = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            case (mode)
                0:       res_ready = 1'b1;
                1:       res_ready = ($urandom_range(0, 1) == 1);
                default: res_ready = (vcyc >= 10) && (vcyc % 2 == 0);
            endcase
            if (pstall && (!res_valid || res_row !== prow || res_data !== pdata)) stall_bad++;
            if (res_valid && res_ready && got_n < 16) begin
                got_row[got_n] = int'(res_row);
                got_d[got_n]   = res_data;
                got_n++;
            end
            pstall = res_valid && !res_ready;
            prow   = res_row;
            pdata  = res_data;
            if (res_valid) vcyc++;
            tick;
            if (done) begin
                done_cnt++;
                if (got_n >= N) begin
                    timed_out = 1'b0;
                    break;
                end
            end
        end
        res_ready = 1'b0;
        tick;
        if (done) done_cnt++;
    endtask

    task automatic test_reset;
        tick; tick;
        rst = 1'b0;
        tick;
        checks++;
        if ({busy, done, err, sa_valid_in, res_valid, ld_ready} !== 6'b000001) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000001", {busy, done, err, sa_valid_in, res_valid, ld_ready});
        end
        checks++;
        if ({sa_a, sa_b} !== '0) begin
            failures++;
            $display("FAIL reset_sa got=%h/%h exp=0", sa_a, sa_b);
        end
        checks++;
        if (res_row !== 3'd0 || res_data !== '0) begin
            failures++;
            $display("FAIL reset_res got=%0d/%h exp=0", res_row, res_data);
        end
    endtask

    task automatic test_timeout;
        model_en = 1'b0;
        load_mats(0);
        do_start;
        for (int c = 0; c < N + 63; c++) tick;
        checks++;
        if (err !== 1'b0 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early got err=%b res_valid=%b exp 0/0", err, res_valid);
        end
        tick;
        checks++;
        if (err !== 1'b1 || res_valid !== 1'b1) begin
            failures++;
            $display("FAIL timeout_set got err=%b res_valid=%b exp 1/1", err, res_valid);
        end
        run_collect(0);
        checks++;
        if (timed_out || got_n != N) begin
            failures++;
            $display("FAIL timeout_rows got=%0d exp=%0d", got_n, N);
        end
        for (int r = 0; r < got_n && r < N; r++) begin
            checks++;
            if (got_row[r] != r || got_d[r] !== '0) begin
                failures++;
                $display("FAIL timeout_data row%0d got=%0d:%h exp=%0d:0", r, got_row[r], got_d[r], r);
            end
        end
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky got=%b exp=1", err);
        end
        model_en = 1'b1;
        gap_pct = 20;
        load_mats(0);
        do_start;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear got=%b exp=0", err);
        end
        run_collect(1);
        for (int r = 0; r < N; r++) begin
            checks++;
            if (got_n != N || got_row[r] != r || got_d[r] !== exp_row(r)) begin
                failures++;
                $display("FAIL rerun_data row%0d got=%h exp=%h", r, got_d[r], exp_row(r));
            end
        end
    endtask

    task automatic test_feed_and_results(input string name, input int kind, input int mode);
        int feed_bad = 0;
        int ones = 0;
        load_mats(kind);
        do_start;
        for (int c = 0; c < N; c++) begin
            if (sa_valid_in) ones++;
            for (int l = 0; l < N; l++)
                if (sa_a[l*DW +: DW] !== ma[l][c] || sa_b[l*DW +: DW] !== mb[c][l]) feed_bad++;
            tick;
        end
        checks++;
        if (ones != N || sa_valid_in !== 1'b0 || feed_bad != 0) begin
            failures++;
            $display("FAIL %s_feed got valid=%0d bad=%0d exp valid=%0d bad=0", name, ones, feed_bad, N);
        end
        run_collect(mode);
        checks++;
        if (timed_out || got_n != N || done_cnt != 1 || err !== 1'b0 || stall_bad != 0) begin
            failures++;
            $display("FAIL %s_ctl got rows=%0d done=%0d err=%b stall=%0d exp %0d/1/0/0",
                     name, got_n, done_cnt, err, stall_bad, N);
        end
        for (int r = 0; r < N; r++) begin
            checks++;
            if (got_row[r] != r || got_d[r] !== exp_row(r)) begin
                failures++;
                $display("FAIL %s_data row%0d got=%0d:%h exp=%0d:%h", name, r, got_row[r], got_d[r], r, exp_row(r));
            end
        end
    endtask

    task automatic test_max;
        logic [N*CW-1:0] c_exp = {N{32'hFFF60005}};
        load_mats(2);
        do_start;
        run_collect(0);
        for (int r = 0; r < N; r++) begin
            checks++;
            if (got_n != N || got_d[r] !== c_exp) begin
                failures++;
                $display("FAIL max_data row%0d got=%h exp=%h", r, got_d[r], c_exp);
            end
        end
    endtask

    task automatic test_protocol;
        logic [N*DW-1:0] d;
        load_mats(0);
        do_start;
        tick;
        ld_valid = 1'b1; ld_sel = 1'b0; ld_row = 3'd0; ld_data = {N{16'($urandom)}}; start = 1'b1;
        #1;
        checks++;
        if (ld_ready !== 1'b0) begin
            failures++;
            $display("FAIL proto_ld_ready got=%b exp=0", ld_ready);
        end
        tick;
        ld_valid = 1'b0; start = 1'b0;
        run_collect(0);
        for (int r = 0; r < N; r++) begin
            checks++;
            if (got_n != N || got_d[r] !== exp_row(r)) begin
                failures++;
                $display("FAIL proto_nochange row%0d got=%h exp=%h", r, got_d[r], exp_row(r));
            end
        end
        tick; tick; tick;
        checks++;
        if (busy !== 1'b0 || sa_valid_in !== 1'b0) begin
            failures++;
            $display("FAIL proto_relaunch got busy=%b svi=%b exp 0/0", busy, sa_valid_in);
        end
        load_mats(0);
        for (int j = 0; j < N; j++) d[j*DW +: DW] = 16'($urandom);
        ld_valid = 1'b1; ld_sel = 1'b1; ld_row = 3'd2; ld_data = d; start = 1'b1;
        for (int j = 0; j < N; j++) mb[2][j] = d[j*DW +: DW];
        tick;
        ld_valid = 1'b0; start = 1'b0;
        compute_expected;
        run_collect(0);
        for (int r = 0; r < N; r++) begin
            checks++;
            if (got_n != N || got_d[r] !== exp_row(r)) begin
                failures++;
                $display("FAIL proto_same_cycle row%0d got=%h exp=%h", r, got_d[r], exp_row(r));
            end
        end
    endtask

    task automatic test_reset_mid;
        load_mats(0);
        do_start;
        tick; tick;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (sa_valid_in !== 1'b0 || busy !== 1'b0 || ld_ready !== 1'b1 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got svi=%b busy=%b ld_ready=%b rv=%b exp 0/0/1/0",
                     sa_valid_in, busy, ld_ready, res_valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick;
        test_feed_and_results("after_reset", 0, 1);
    endtask

    initial begin
        test_reset;
        test_timeout;
        gap_pct = 30;
        test_feed_and_results("identity", 1, 0);
        test_max;
        for (int it = 0; it < 3; it++) begin
            gap_pct = 40;
            test_feed_and_results("random", 0, 1);
        end
        gap_pct = 10;
        test_feed_and_results("backpressure", 0, 2);
        test_protocol;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
